// File: rtl/window_hash_pkg.sv
// window_hash_pkg: shared hash types and the per-byte update step.
// Hash values are carried in a 32-bit container; callers pass the live width.
package window_hash_pkg;

    localparam int HASH_MAX_W = 32;
    localparam int ROT_AMT    = 3;

    typedef logic [HASH_MAX_W-1:0] hash_t;

    function automatic hash_t hash_mask(input int w);
        if (w >= HASH_MAX_W) return '1;
        return (hash_t'(1) << w) - hash_t'(1);
    endfunction

    function automatic hash_t rotl(input hash_t h, input int n, input int w);
        hash_t x;
        x = h & hash_mask(w);
        return ((x << n) | (x >> (w - n))) & hash_mask(w);
    endfunction

    function automatic hash_t hash_step(input hash_t h, input logic [7:0] b,
                                        input int w);
        return rotl(h, ROT_AMT, w) ^ hash_t'(b);
    endfunction

endpackage

// File: rtl/window_hash_lane.sv
// window_hash_lane: folds window bytes [LO, HI) into a running hash.
// Bytes at or beyond the lane length leave the hash untouched.
module window_hash_lane
    import window_hash_pkg::*;
#(
    parameter int HASH_W = 12,
    parameter int LEN_W  = 6,
    parameter int LO     = 0,
    parameter int HI     = 10
) (
    input  logic [(HI-LO)*8-1:0] bytes_i,
    input  logic [HASH_W-1:0]    h_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic [HASH_W-1:0]    h_o
);

    // unrolled byte chain, each step gated by the lane length
    always_comb begin
        h_o = h_i;
        for (int k = LO; k < HI; k++) begin
            if (k < int'(len_i)) begin
                h_o = HASH_W'(hash_step(hash_t'(h_o),
                                        bytes_i[(k-LO)*8 +: 8], HASH_W));
            end
        end
    end

endmodule

// File: rtl/window_hash.sv
// window_hash: two-stage elastic per-lane window hasher.
// Define WINDOW_HASH_FULL_ONLY_EN to hash only lanes holding a full window.
module window_hash
    import window_hash_pkg::*;
#(
    parameter int          SYMBOLS       = 8,
    parameter int          WINDOW_SIZE   = 20,
    parameter int          WINDOW_SIZE_W = (WINDOW_SIZE == 1) ? 1
                                         : $clog2(WINDOW_SIZE),
    parameter int          HASH_W        = 12,
    parameter logic [31:0] SEED          = 32'h5A5
) (
    input  logic                                 clk_i,
    input  logic                                 arst_n_i,
    input  logic [SYMBOLS*WINDOW_SIZE*8-1:0]     windows_data_i,
    input  logic [SYMBOLS*(WINDOW_SIZE_W+1)-1:0] windows_data_valid_bytes_i,
    output logic                                 windows_data_ready_o,
    output logic [SYMBOLS*HASH_W-1:0]            hash_o,
    output logic [SYMBOLS-1:0]                   hash_lane_valid_o,
    output logic                                 hash_valid_o,
    input  logic                                 hash_ready_i
);

    localparam int LEN_W    = WINDOW_SIZE_W + 1;
    localparam int SPLIT    = (WINDOW_SIZE + 1) / 2;
    localparam int WIN_BITS = WINDOW_SIZE * 8;
    localparam int LO_BITS  = SPLIT * 8;
    localparam int HI_BITS  = (WINDOW_SIZE - SPLIT) * 8;
    localparam logic [HASH_W-1:0] HSEED = SEED[HASH_W-1:0];

    logic [SYMBOLS-1:0] lane_ok;
    logic               s1_adv;
    logic               s2_adv;
    logic               load;

    logic               s1_full;
    logic [SYMBOLS-1:0] s1_mask;
    logic [HASH_W-1:0]  s1_h   [SYMBOLS];
    logic [HI_BITS-1:0] s1_hi  [SYMBOLS];
    logic [LEN_W-1:0]   s1_len [SYMBOLS];

    logic [HASH_W-1:0]  h1 [SYMBOLS];
    logic [HASH_W-1:0]  h2 [SYMBOLS];

    for (genvar g = 0; g < SYMBOLS; g++) begin : g_lane
        logic [LEN_W-1:0] len_in;
        assign len_in = windows_data_valid_bytes_i[g*LEN_W +: LEN_W];

`ifdef WINDOW_HASH_FULL_ONLY_EN
        assign lane_ok[g] = (len_in == LEN_W'(WINDOW_SIZE));
`else
        assign lane_ok[g] = (len_in != '0);
`endif

        window_hash_lane #(
            .HASH_W (HASH_W),
            .LEN_W  (LEN_W),
            .LO     (0),
            .HI     (SPLIT)
        ) u_lo (
            .bytes_i (windows_data_i[g*WIN_BITS +: LO_BITS]),
            .h_i     (HSEED),
            .len_i   (len_in),
            .h_o     (h1[g])
        );

        window_hash_lane #(
            .HASH_W (HASH_W),
            .LEN_W  (LEN_W),
            .LO     (SPLIT),
            .HI     (WINDOW_SIZE)
        ) u_hi (
            .bytes_i (s1_hi[g]),
            .h_i     (s1_h[g]),
            .len_i   (s1_len[g]),
            .h_o     (h2[g])
        );

        a_len_legal : assert property (
            @(posedge clk_i) disable iff (!arst_n_i)
            len_in <= LEN_W'(WINDOW_SIZE)
        );
    end

    assign s2_adv               = !hash_valid_o || hash_ready_i;
    assign s1_adv               = !s1_full || s2_adv;
    assign windows_data_ready_o = s1_adv;
    assign load                 = s1_adv && (|lane_ok);
    assign hash_valid_o         = |hash_lane_valid_o;

    // occupancy: an empty output mask doubles as "stage 2 empty"
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_full           <= 1'b0;
            hash_lane_valid_o <= '0;
        end else begin
            if (s1_adv) begin
                s1_full <= |lane_ok;
            end
            if (s2_adv) begin
                hash_lane_valid_o <= s1_full ? s1_mask : '0;
            end
        end
    end

    // stage 1 payload: partial hash, upper bytes and length per lane
    always_ff @(posedge clk_i) begin
        if (load) begin
            s1_mask <= lane_ok;
            for (int i = 0; i < SYMBOLS; i++) begin
                s1_h[i]   <= h1[i];
                s1_hi[i]  <= windows_data_i[i*WIN_BITS+LO_BITS +: HI_BITS];
                s1_len[i] <= windows_data_valid_bytes_i[i*LEN_W +: LEN_W];
            end
        end
    end

    // stage 2: finish the upper bytes, fold in length; idle lanes read 0
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            hash_o <= '0;
        end else if (s2_adv && s1_full) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                hash_o[i*HASH_W +: HASH_W] <=
                    s1_mask[i] ? (h2[i] ^ HASH_W'(s1_len[i])) : '0;
            end
        end
    end

endmodule

// File: tb/tb_window_hash.sv
// tb_window_hash: randomized scoreboard bench for window_hash.
// Works with or without WINDOW_HASH_FULL_ONLY_EN defined.
module tb_window_hash;

    localparam int SYM    = 8;
    localparam int WS     = 20;
    localparam int WSW    = 5;
    localparam int LW     = WSW + 1;
    localparam int HW     = 12;
    localparam int SEED_V = 'h5A5;

    typedef struct {
        logic [SYM*WS*8-1:0] data;
        logic [SYM*LW-1:0]   vb;
    } word_t;

    typedef struct {
        logic [SYM*HW-1:0] h;
        logic [SYM-1:0]    m;
    } exp_t;

    logic                clk;
    logic                arst_n;
    logic [SYM*WS*8-1:0] data;
    logic [SYM*LW-1:0]   vb;
    logic                ready;
    logic [SYM*HW-1:0]   hash;
    logic [SYM-1:0]      mask;
    logic                valid;
    logic                hash_ready;

    logic                ready0;
    logic [SYM*HW-1:0]   hash0;
    logic [SYM-1:0]      mask0;
    logic                valid0;

    int    total, passed;
    int    acc_count, ready_low_cnt, out_count;
    int    run, max_run;
    int    mode;
    bit    idle_en;
    bit    presenting;
    bit    prev_stall;
    logic [SYM*HW-1:0] held_h;
    logic [SYM-1:0]    held_m;
    logic [SYM-1:0]    last_mask;
    word_t to_send[$];
    exp_t  exp_q[$];

    window_hash #(
        .SYMBOLS(SYM), .WINDOW_SIZE(WS), .WINDOW_SIZE_W(WSW),
        .HASH_W(HW), .SEED(32'h5A5)
    ) u_dut (
        .clk_i                      (clk),
        .arst_n_i                   (arst_n),
        .windows_data_i             (data),
        .windows_data_valid_bytes_i (vb),
        .windows_data_ready_o       (ready),
        .hash_o                     (hash),
        .hash_lane_valid_o          (mask),
        .hash_valid_o               (valid),
        .hash_ready_i               (hash_ready)
    );

    window_hash #(
        .SYMBOLS(SYM), .WINDOW_SIZE(WS), .WINDOW_SIZE_W(WSW),
        .HASH_W(HW), .SEED(32'h0)
    ) u_dut0 (
        .clk_i                      (clk),
        .arst_n_i                   (arst_n),
        .windows_data_i             (data),
        .windows_data_valid_bytes_i (vb),
        .windows_data_ready_o       (ready0),
        .hash_o                     (hash0),
        .hash_lane_valid_o          (mask0),
        .hash_valid_o               (valid0),
        .hash_ready_i               (hash_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic exp_t model(input word_t w);
        exp_t e;
        int   len, h, b;
        bit   ok;
        e.h = '0;
        e.m = '0;
        for (int i = 0; i < SYM; i++) begin
            len = int'(w.vb[i*LW +: LW]);
`ifdef WINDOW_HASH_FULL_ONLY_EN
            ok = (len == WS);
`else
            ok = (len > 0);
`endif
            if (ok) begin
                h = SEED_V % 4096;
                for (int k = 0; k < len; k++) begin
                    b = int'(w.data[(i*WS+k)*8 +: 8]);
                    h = (((h * 8) % 4096) + (h / 512)) ^ b;
                end
                e.h[i*HW +: HW] = HW'(h ^ len);
                e.m[i] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic word_t rand_word(input bit all_full);
        word_t w;
        int    r;
        for (int j = 0; j < SYM*WS; j++) w.data[j*8 +: 8] = 8'($urandom);
        for (int i = 0; i < SYM; i++) begin
            r = $urandom_range(0, 3);
            if (all_full || r == 1 || r == 3) w.vb[i*LW +: LW] = LW'(WS);
            else if (r == 0) w.vb[i*LW +: LW] = '0;
            else w.vb[i*LW +: LW] = LW'($urandom_range(1, WS-1));
        end
        if (w.vb == '0) w.vb[LW-1:0] = LW'(WS);
        return w;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((to_send.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #2;
    endtask

    // downstream ready pattern
    always begin
        @(negedge clk);
        case (mode)
            0:       hash_ready = 1'b0;
            1:       hash_ready = 1'b1;
            default: hash_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // driver: present queue head, hold it until the DUT takes it
    always begin
        exp_t e;
        @(negedge clk);
        if (arst_n && to_send.size() > 0 &&
            (presenting || !idle_en || $urandom_range(0, 3) != 0)) begin
            data = to_send[0].data;
            vb = to_send[0].vb;
            presenting = 1'b1;
        end else begin
            data = '0;
            vb = '0;
            presenting = 1'b0;
        end
        #4;
        if (!arst_n) begin
            presenting = 1'b0;
        end else if (presenting && ready) begin
            e = model(to_send[0]);
            if (e.m != '0) exp_q.push_back(e);
            void'(to_send.pop_front());
            acc_count++;
            presenting = 1'b0;
        end else if (presenting) begin
            ready_low_cnt++;
        end
    end

    // monitor: scoreboard pop on every output transfer, hold check on stalls
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (!arst_n) begin
            prev_stall = 1'b0;
            run = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", valid, 1'b1);
                check("hold_hash", hash, held_h);
                check("hold_mask", mask, held_m);
            end
            if (valid && hash_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: got hash %0h mask %0h expected none",
                             hash, mask);
                end else begin
                    e = exp_q.pop_front();
                    check("hash", hash, e.h);
                    check("mask", mask, e.m);
                end
                out_count++;
                last_mask = mask;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            prev_stall = valid && !hash_ready;
            held_h = hash;
            held_m = mask;
        end
    end

    initial begin
        word_t w;
        int    start, outs, n;
        total = 0;
        passed = 0;
        acc_count = 0;
        ready_low_cnt = 0;
        out_count = 0;
        run = 0;
        max_run = 0;
        mode = 1;
        idle_en = 1'b0;
        presenting = 1'b0;
        prev_stall = 1'b0;
        hash_ready = 1'b1;
        data = '0;
        vb = '0;
        arst_n = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", valid, 1'b0);
        check("rst_mask", mask, '0);
        check("rst_hash", hash, '0);
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #2;
        check("rst_ready", ready, 1'b1);

        // lane 0 = {01,02}, L=2; SEED=0 instance gives 12'h008
        w.data = '0;
        w.vb = '0;
        w.data[7:0] = 8'h01;
        w.data[15:8] = 8'h02;
        w.vb[LW-1:0] = LW'(2);
        start = acc_count;
        to_send.push_back(w);
        n = 0;
        while (acc_count == start && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 20) fail_now("directed_accept");
        check("lat_one_edge", valid0, 1'b0);
        @(posedge clk);
        #2;
`ifdef WINDOW_HASH_FULL_ONLY_EN
        check("dir_valid", valid0, 1'b0);
        check("dir_mask", mask0, 8'h00);
        check("dir_hash", hash0[HW-1:0], 12'h000);
`else
        check("dir_valid", valid0, 1'b1);
        check("dir_mask", mask0, 8'h01);
        check("dir_hash", hash0[HW-1:0], 12'h008);
`endif
        wait_drain(100);

        // back-to-back full words
        ready_low_cnt = 0;
        max_run = 0;
        for (int i = 0; i < 400; i++) to_send.push_back(rand_word(1'b1));
        wait_drain(2000);
        check("b2b_ready_low", ready_low_cnt, 0);
        check("b2b_run", max_run, 400);

        // downstream stall while 3 words arrive
        mode = 0;
        start = acc_count;
        outs = out_count;
        ready_low_cnt = 0;
        for (int i = 0; i < 3; i++) to_send.push_back(rand_word(1'b1));
        repeat (5) @(posedge clk);
        #2;
        check("stall_accepted", acc_count - start, 2);
        check("stall_ready_low", ready_low_cnt, 3);
        check("stall_no_output", out_count - outs, 0);
        mode = 1;
        wait_drain(200);
        check("stall_accept_all", acc_count - start, 3);
        check("stall_outputs", out_count - outs, 3);

        // mixed lane counts at a packet tail
        w = rand_word(1'b0);
        w.vb = '0;
        w.vb[0*LW +: LW] = LW'(20);
        w.vb[1*LW +: LW] = LW'(19);
        w.vb[2*LW +: LW] = LW'(1);
        to_send.push_back(w);
        wait_drain(200);
`ifdef WINDOW_HASH_FULL_ONLY_EN
        check("mixed_mask", last_mask, 8'h01);
        w = rand_word(1'b0);
        for (int i = 0; i < SYM; i++) w.vb[i*LW +: LW] = LW'(5);
        start = acc_count;
        outs = out_count;
        to_send.push_back(w);
        wait_drain(200);
        check("short_accepted", acc_count - start, 1);
        check("short_no_output", out_count - outs, 0);
`else
        check("mixed_mask", last_mask, 8'h07);
`endif

        // random traffic on both sides
        mode = 2;
        idle_en = 1'b1;
        start = acc_count;
        for (int i = 0; i < 10000; i++) to_send.push_back(rand_word(1'b0));
        wait_drain(60000);
        check("rand_accept_all", acc_count - start, 10000);

        // reset with both stages full
        mode = 0;
        idle_en = 1'b0;
        for (int i = 0; i < 3; i++) to_send.push_back(rand_word(1'b1));
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_valid", valid, 1'b1);
        check("pre_rst_ready", ready, 1'b0);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        to_send.delete();
        exp_q.delete();
        #1;
        check("arst_valid", valid, 1'b0);
        check("arst_mask", mask, '0);
        check("arst_hash", hash, '0);
        repeat (2) @(negedge clk);
        #2;
        arst_n = 1'b1;
        mode = 1;
        @(posedge clk);
        #2;
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_valid", valid, 1'b0);
        start = acc_count;
        for (int i = 0; i < 20; i++) to_send.push_back(rand_word(1'b0));
        wait_drain(500);
        check("post_rst_accept", acc_count - start, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
